// File: rtl/data_mem_ctrl.sv
// Data-memory responder: serves loads on a single-outstanding req/ack bus and
// buffers stores in a small FIFO that drains to the bus when no load is waiting.
module data_mem_ctrl #(
  parameter int unsigned SB_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RDEN,
  input  logic [31:0] RDADDR,
  input  logic        WREN,
  input  logic [31:0] WADDR,
  input  logic [3:0]  WSTRB,
  input  logic [31:0] WDATA,
  output logic [31:0] DATA_RDDATA,
  output logic        STALL,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [3:0]  MEM_STRB,
  output logic [31:0] MEM_WDATA,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA
);

  localparam int unsigned PW = $clog2(SB_DEPTH);
  localparam logic [PW:0] SB_FULL = SB_DEPTH[PW:0];

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t      state_q, state_d;
  logic [29:0] sb_addr [SB_DEPTH];
  logic [3:0]  sb_strb [SB_DEPTH];
  logic [31:0] sb_data [SB_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, offs;
  logic [PW:0]   count;
  logic        wr_done;
  logic        fifo_full, fifo_empty, hit, hazard, accept, enq, deq, ack;
  logic        req_d, we_d;
  logic [31:0] addr_d, wdata_d, rdata_d;
  logic [3:0]  strb_d;

  assign fifo_full  = (count == SB_FULL);
  assign fifo_empty = (count == '0);
  assign ack        = MEM_ACK & MEM_REQ;

  // An entry is live when its distance from the head is below the fill count.
  always_comb begin
    hit  = 1'b0;
    offs = '0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      offs = PW'(i) - rd_ptr;
      if (({1'b0, offs} < count) && (sb_addr[i] == RDADDR[31:2]))
        hit = 1'b1;
    end
    if (WREN && !wr_done && (WADDR[31:2] == RDADDR[31:2]))
      hit = 1'b1;
    hazard = RDEN & hit;
  end

  assign STALL  = (state_q == RD) | (RDEN & ((state_q != IDLE) | hazard))
                | (WREN & ~wr_done & fifo_full);
  assign accept = RDEN & ~STALL;
  assign enq    = WREN & ~fifo_full & ~wr_done;

  always_comb begin
    state_d = state_q;
    req_d   = MEM_REQ;
    we_d    = MEM_WE;
    addr_d  = MEM_ADDR;
    strb_d  = MEM_STRB;
    wdata_d = MEM_WDATA;
    rdata_d = DATA_RDDATA;
    deq     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RD;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = {RDADDR[31:2], 2'b00};
          strb_d  = '0;
        end else if (!fifo_empty) begin
          state_d = WR;
          req_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = {sb_addr[rd_ptr], 2'b00};
          strb_d  = sb_strb[rd_ptr];
          wdata_d = sb_data[rd_ptr];
        end
      end
      RD: begin
        if (ack) begin
          rdata_d = MEM_RDATA;
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      WR: begin
        if (ack) begin
          deq     = 1'b1;
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      MEM_REQ     <= 1'b0;
      MEM_WE      <= 1'b0;
      MEM_ADDR    <= '0;
      MEM_STRB    <= '0;
      MEM_WDATA   <= '0;
      DATA_RDDATA <= '0;
      wr_done     <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      state_q     <= state_d;
      MEM_REQ     <= req_d;
      MEM_WE      <= we_d;
      MEM_ADDR    <= addr_d;
      MEM_STRB    <= strb_d;
      MEM_WDATA   <= wdata_d;
      DATA_RDDATA <= rdata_d;
      // Remember an enqueue made while frozen so the held store is not taken twice.
      wr_done     <= STALL ? (wr_done | enq) : 1'b0;
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      unique case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (enq) begin
      sb_addr[wr_ptr] <= WADDR[31:2];
      sb_strb[wr_ptr] <= WSTRB;
      sb_data[wr_ptr] <= WDATA;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: directed loads/stores, expected bus
// transfers and load data queued at issue, checked by an independent monitor.
module tb_data_mem_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        RDEN = 1'b0;
  logic [31:0] RDADDR = '0;
  logic        WREN = 1'b0;
  logic [31:0] WADDR = '0;
  logic [3:0]  WSTRB = '0;
  logic [31:0] WDATA = '0;
  logic [31:0] DATA_RDDATA;
  logic        STALL;
  logic        MEM_REQ, MEM_WE;
  logic [31:0] MEM_ADDR, MEM_WDATA;
  logic [3:0]  MEM_STRB;
  logic        MEM_ACK;
  logic [31:0] MEM_RDATA = '0;
  logic        ack_en = 1'b0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } bus_t;

  bus_t        exp_bus[$];
  logic [31:0] exp_rd[$];
  bus_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          wr_xfers = 0;
  int          rd_pending = 0;
  int          w0;

  assign MEM_ACK = MEM_REQ & ack_en;

  data_mem_ctrl #(.SB_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .RDEN(RDEN), .RDADDR(RDADDR), .WREN(WREN),
    .WADDR(WADDR), .WSTRB(WSTRB), .WDATA(WDATA), .DATA_RDDATA(DATA_RDDATA),
    .STALL(STALL), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_STRB(MEM_STRB), .MEM_WDATA(MEM_WDATA), .MEM_ACK(MEM_ACK),
    .MEM_RDATA(MEM_RDATA)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_w(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    bus_t e;
    e.we = 1'b1; e.addr = a; e.strb = s; e.wdata = d;
    exp_bus.push_back(e);
  endtask

  task automatic push_r(input logic [31:0] a, input logic [31:0] d);
    bus_t e;
    e.we = 1'b0; e.addr = a; e.strb = 4'b0000; e.wdata = '0;
    exp_bus.push_back(e);
    exp_rd.push_back(d);
  endtask

  task automatic step;
    @(posedge CLK);
    #2;
  endtask

  task automatic wait_nostall(input string name);
    int n = 0;
    #1;
    while (STALL && n < 50) begin
      step; #1;
      n++;
    end
    chk(name, 32'(STALL), 32'd0);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_bus.size() != 0 || rd_pending != 0) && n < 100) begin
      step;
      n++;
    end
    chk(name, 32'(exp_bus.size()), 32'd0);
  endtask

  task automatic load_zero_wait(input logic [31:0] d);
    ack_en = 1'b1;
    MEM_RDATA = d;
    push_r(32'h100, d);
    step; RDEN = 1'b1; RDADDR = 32'h100; #1;
    chk("ld0 stall t", 32'(STALL), 32'd0);
    step; #1;
    chk("ld0 req", 32'(MEM_REQ), 32'd1);
    chk("ld0 we", 32'(MEM_WE), 32'd0);
    chk("ld0 addr", MEM_ADDR, 32'h100);
    chk("ld0 stall t+1", 32'(STALL), 32'd1);
    step; RDEN = 1'b0; #1;
    chk("ld0 stall t+2", 32'(STALL), 32'd0);
    chk("ld0 data t+2", DATA_RDDATA, d);
    step;
  endtask

  // Monitor: every completed bus transfer must match the head of the queue;
  // load data is compared the cycle after the read acknowledge.
  always @(negedge CLK) begin
    if (rd_pending != 0) begin
      rd_pending = 0;
      if (exp_rd.size() == 0) begin
        checks++; errors++;
        $display("FAIL load data: got %h expected none", DATA_RDDATA);
      end else begin
        chk("mon load data", DATA_RDDATA, exp_rd.pop_front());
      end
    end
    if (RST && MEM_REQ && MEM_ACK) begin
      if (exp_bus.size() == 0) begin
        checks++; errors++;
        $display("FAIL bus xfer: got we=%0d addr=%h expected none", MEM_WE, MEM_ADDR);
      end else begin
        mon_e = exp_bus.pop_front();
        chk("mon we", 32'(MEM_WE), 32'(mon_e.we));
        chk("mon addr", MEM_ADDR, mon_e.addr);
        chk("mon strb", 32'(MEM_STRB), 32'(mon_e.strb));
        if (mon_e.we) begin
          chk("mon wdata", MEM_WDATA, mon_e.wdata);
          wr_xfers++;
        end else begin
          rd_pending = 1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 RST = 1'b0;
    #2;
    chk("rst req", 32'(MEM_REQ), 32'd0);
    chk("rst we", 32'(MEM_WE), 32'd0);
    chk("rst addr", MEM_ADDR, 32'd0);
    chk("rst strb", 32'(MEM_STRB), 32'd0);
    chk("rst wdata", MEM_WDATA, 32'd0);
    chk("rst rddata", DATA_RDDATA, 32'd0);
    chk("rst stall", 32'(STALL), 32'd0);
    step; step;
    RST = 1'b1;
    step;

    // Load on a zero-wait bus
    load_zero_wait(32'hDEADBEEF);

    // Single store drains two cycles later, never stalling
    ack_en = 1'b1;
    push_w(32'h200, 4'b1000, 32'hAB000000);
    step; WREN = 1'b1; WADDR = 32'h203; WSTRB = 4'b1000; WDATA = 32'hAB000000; #1;
    chk("st stall t", 32'(STALL), 32'd0);
    step; WREN = 1'b0; #1;
    chk("st stall t+1", 32'(STALL), 32'd0);
    chk("st req t+1", 32'(MEM_REQ), 32'd0);
    step; #1;
    chk("st req t+2", 32'(MEM_REQ), 32'd1);
    chk("st we t+2", 32'(MEM_WE), 32'd1);
    chk("st addr t+2", MEM_ADDR, 32'h200);
    chk("st strb t+2", 32'(MEM_STRB), 32'h8);
    chk("st stall t+2", 32'(STALL), 32'd0);
    drain("st drain");

    // Read-after-write hazard on the same word
    ack_en = 1'b0;
    MEM_RDATA = 32'h55AA55AA;
    push_w(32'h300, 4'b1111, 32'h11112222);
    push_r(32'h300, 32'h55AA55AA);
    step; WREN = 1'b1; WADDR = 32'h300; WSTRB = 4'b1111; WDATA = 32'h11112222; #1;
    chk("raw st stall", 32'(STALL), 32'd0);
    step; WREN = 1'b0; RDEN = 1'b1; RDADDR = 32'h302; #1;
    chk("raw stall", 32'(STALL), 32'd1);
    repeat (4) begin
      step; #1;
      chk("raw stall held", 32'(STALL), 32'd1);
      chk("raw no read", 32'(MEM_REQ && !MEM_WE), 32'd0);
    end
    ack_en = 1'b1;
    wait_nostall("raw accept");
    step; RDEN = 1'b0; #1;
    chk("raw read req", 32'(MEM_REQ && !MEM_WE), 32'd1);
    chk("raw read addr", MEM_ADDR, 32'h300);
    step; #1;
    chk("raw data", DATA_RDDATA, 32'h55AA55AA);
    drain("raw drain");

    // Store buffer full: fifth store stalls until the first write is acknowledged
    ack_en = 1'b0;
    w0 = wr_xfers;
    for (int i = 0; i < 5; i++)
      push_w(32'h400 + 32'(4 * i), 4'b1111, 32'hA0000000 + 32'(i));
    for (int i = 0; i < 4; i++) begin
      step; WREN = 1'b1; WADDR = 32'h400 + 32'(4 * i); WSTRB = 4'b1111;
      WDATA = 32'hA0000000 + 32'(i); #1;
      chk("full st stall", 32'(STALL), 32'd0);
    end
    step; WADDR = 32'h410; WDATA = 32'hA0000004; #1;
    chk("full 5th stall", 32'(STALL), 32'd1);
    repeat (2) begin
      step; #1;
      chk("full stall held", 32'(STALL), 32'd1);
    end
    ack_en = 1'b1;
    step; #1;
    chk("full release", 32'(STALL), 32'd0);
    step; WREN = 1'b0;
    drain("full drain");
    repeat (4) step;
    chk("full write count", 32'(wr_xfers - w0), 32'd5);

    // Load (and a held store) arriving while a write is outstanding
    ack_en = 1'b0;
    w0 = wr_xfers;
    MEM_RDATA = 32'h12345678;
    push_w(32'h500, 4'b1111, 32'hA5A5A5A5);
    step; WREN = 1'b1; WADDR = 32'h500; WSTRB = 4'b1111; WDATA = 32'hA5A5A5A5; #1;
    chk("lw st stall", 32'(STALL), 32'd0);
    step; WREN = 1'b0;
    step; #1;
    chk("lw in wr", 32'(MEM_REQ && MEM_WE), 32'd1);
    push_r(32'h600, 32'h12345678);
    push_w(32'h700, 4'b0011, 32'h0000BEEF);
    RDEN = 1'b1; RDADDR = 32'h600;
    WREN = 1'b1; WADDR = 32'h700; WSTRB = 4'b0011; WDATA = 32'h0000BEEF; #1;
    chk("lw stall", 32'(STALL), 32'd1);
    repeat (2) begin
      step; #1;
      chk("lw stall held", 32'(STALL), 32'd1);
    end
    ack_en = 1'b1;
    step; #1;
    chk("lw idle stall", 32'(STALL), 32'd0);
    chk("lw idle req", 32'(MEM_REQ), 32'd0);
    step; RDEN = 1'b0; WREN = 1'b0; #1;
    chk("lw read req", 32'(MEM_REQ && !MEM_WE), 32'd1);
    chk("lw read addr", MEM_ADDR, 32'h600);
    drain("lw drain");
    repeat (4) step;
    chk("lw write count", 32'(wr_xfers - w0), 32'd2);

    // Asynchronous reset while a read is outstanding
    ack_en = 1'b0;
    step; RDEN = 1'b1; RDADDR = 32'h800; #1;
    chk("ar accept", 32'(STALL), 32'd0);
    step; RDEN = 1'b0; #1;
    chk("ar in rd", 32'(MEM_REQ), 32'd1);
    RST = 1'b0;
    #1;
    chk("ar req", 32'(MEM_REQ), 32'd0);
    chk("ar rddata", DATA_RDDATA, 32'd0);
    chk("ar addr", MEM_ADDR, 32'd0);
    chk("ar stall", 32'(STALL), 32'd0);
    step; step;
    RST = 1'b1;
    step;
    load_zero_wait(32'hCAFEF00D);
    drain("final drain");

    chk("exp bus empty", 32'(exp_bus.size()), 32'd0);
    chk("exp rd empty", 32'(exp_rd.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Data-memory responder for the RV32I core's data port. It serves the load requests issued by the exec stage and the store requests issued by the mem stage (the M_STORE_* bundle).
- Loads: returns read data on DATA_RDDATA for the mem stage's load-extension logic.
- Stores: buffers them in a small FIFO and drains them to a simple req/ack memory bus.
- Drives the pipeline STALL whenever a load result is not yet available or the store buffer cannot take a store.

Parameters:
SB_DEPTH, 4, store-buffer entries; must be a power of two, minimum 2.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; asynchronous, active-low.
- RDEN  in  1  load request from the exec stage, held while STALL=1.
- RDADDR  in  32  load address; word-aligned access, bits [1:0] ignored.
- WREN  in  1  store request (mem stage M_STORE_WREN), held while STALL=1.
- WADDR  in  32  store address; bits [1:0] ignored.
- WSTRB  in  4  store byte strobes.
- WDATA  in  32  store data, already lane-aligned.
- DATA_RDDATA  out  32  data from the last completed load.
- STALL  out  1  pipeline stall request, combinational.
- MEM_REQ  out  1  bus request, registered.
- MEM_WE  out  1  1 = write, 0 = read; registered.
- MEM_ADDR  out  32  word address with [1:0]=0; registered.
- MEM_STRB  out  4  write strobes; 4'b0000 on reads.
- MEM_WDATA  out  32  write data.
- MEM_ACK  in  1  transfer complete; may be asserted in the first MEM_REQ cycle.
- MEM_RDATA  in  32  read data, valid when MEM_ACK=1 and MEM_WE=0.

Behaviour:
- Reset (RST=0, asynchronous):
  - FSM returns to IDLE; FIFO is emptied; wr_done=0.
  - MEM_REQ, MEM_WE, MEM_ADDR, MEM_STRB, MEM_WDATA and DATA_RDDATA all go to 0.
  - STALL therefore evaluates to 0 unless WREN/RDEN inputs force it. Any in-flight bus transfer is abandoned.
- FSM states:
  - IDLE: no transfer in flight.
  - RD: read outstanding.
  - WR: write outstanding.
- Hazard: RDEN=1 and RDADDR[31:2] equals the [31:2] address of any valid FIFO entry, or equals WADDR[31:2] while WREN=1 and wr_done=0.
- Stall: STALL = (state==RD) | (RDEN & (state!=IDLE | hazard)) | (WREN & !wr_done & fifo_full).
- Load accept: accept = RDEN & !STALL, which only occurs in IDLE. At the edge, the FSM goes to RD with MEM_REQ=1, MEM_WE=0, MEM_ADDR={RDADDR[31:2],2'b00}, MEM_STRB=0.
- RD state:
  - MEM_* outputs held stable until MEM_ACK.
  - On the ACK edge, DATA_RDDATA<=MEM_RDATA, MEM_REQ<=0, go to IDLE.
  - STALL is therefore 1 from the cycle after accept through the ACK cycle, and 0 in the cycle DATA_RDDATA becomes valid.
  - Minimum load latency: 1 stall cycle.
- DATA_RDDATA holds its value until the next read completes.
- Store enqueue:
  - Condition: WREN & !fifo_full & !wr_done.
  - If this happens while STALL=1, wr_done<=1.
  - wr_done<=0 on any cycle with STALL=0, so each store is enqueued exactly once even while the mem stage is frozen.
  - Simultaneous enqueue and dequeue on a full FIFO is not permitted; the full check uses the current count.
- Store drain:
  - In IDLE, with no accept this cycle and FIFO not empty, issue the head entry: go to WR with MEM_REQ=1, MEM_WE=1, and ADDR/STRB/WDATA from the head.
  - On MEM_ACK: pop the head, MEM_REQ<=0, go to IDLE.
  - One idle bubble cycle between consecutive transfers.
- Priority in IDLE: an accepted load beats a store drain. A hazard load waits until the matching entries have drained.
- FIFO: circular buffer with wrapping read/write pointers and a count of 0..SB_DEPTH. full = (count==SB_DEPTH); empty = (count==0).
- MEM_ACK while MEM_REQ=0 is ignored.

Test Plan:
- Load, 0-wait bus:
  - Stimulus: RDADDR=0x100 with RDEN=1 at cycle t; MEM_ACK=1 with MEM_RDATA=0xDEADBEEF at t+1.
  - Required: MEM_REQ=1, MEM_WE=0, MEM_ADDR=0x100 at t+1; STALL=1 only at t+1; DATA_RDDATA=0xDEADBEEF at t+2.
- Store drain:
  - Stimulus: WREN=1 with WADDR=0x203, WSTRB=4'b1000, WDATA=0xAB000000 for one cycle; ACK immediately.
  - Required: at t+2, MEM_REQ=1, MEM_WE=1, MEM_ADDR=0x200, MEM_STRB=4'b1000; STALL never asserted.
- RAW hazard:
  - Stimulus: store to 0x300 queued with ACK held low; then RDEN with RDADDR=0x302.
  - Required: STALL=1 and no read issued until the write ACK. Then the read to 0x300 is issued and the returned data appears on DATA_RDDATA.
- Buffer full:
  - Stimulus: SB_DEPTH=4, MEM_ACK held 0, 5 back-to-back stores.
  - Required: the 5th WREN raises STALL. After the first write ACK, exactly one enqueue of store 5 occurs, and exactly 5 MEM write transfers complete in total.
- Load during write:
  - Stimulus: RDEN arrives while in WR.
  - Required: STALL=1, the write completes first, then the read is issued in the cycle after returning to IDLE.
- Async reset mid-read:
  - Stimulus: RST=0 while in RD.
  - Required: MEM_REQ=0 and DATA_RDDATA=0 immediately, without a clock edge. After release, the first load behaves as in the first scenario.
